// File: rtl/rc4_prga_decryptor.sv
// RC4 pseudo-random generation loop: walks the scheduled S-box, swaps S[i]/S[j],
// fetches the keystream byte and writes ciphertext XOR keystream into the decrypted RAM.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | after reset, waiting for start
//  INC_I    | i <= i+1
//  RD_SI    | present S address i
//  WAIT_SI  | S read in flight
//  LATCH_SI | si <= S[i]
//  CALC_J   | j <= j+si
//  RD_SJ    | present S address j
//  WAIT_SJ  | S read in flight
//  LATCH_SJ | sj <= S[j]
//  WR_I     | S[i] <= sj
//  WR_J     | S[j] <= si
//  RD_F     | present S address si+sj
//  WAIT_F   | S read in flight
//  LATCH_F  | f <= S[si+sj]
//  WR_DEC   | dec[k] <= f ^ rom[k]
//  NEXT_K   | last byte -> DONE, else k <= k+1
//  DONE     | message finished, waiting for start

module rc4_prga_decryptor #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_q,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] rom_address,
    output logic [MSG_AW-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] ST_IDLE     = 5'd0;
    localparam logic [4:0] ST_INC_I    = 5'd1;
    localparam logic [4:0] ST_RD_SI    = 5'd2;
    localparam logic [4:0] ST_WAIT_SI  = 5'd3;
    localparam logic [4:0] ST_LATCH_SI = 5'd4;
    localparam logic [4:0] ST_CALC_J   = 5'd5;
    localparam logic [4:0] ST_RD_SJ    = 5'd6;
    localparam logic [4:0] ST_WAIT_SJ  = 5'd7;
    localparam logic [4:0] ST_LATCH_SJ = 5'd8;
    localparam logic [4:0] ST_WR_I     = 5'd9;
    localparam logic [4:0] ST_WR_J     = 5'd10;
    localparam logic [4:0] ST_RD_F     = 5'd11;
    localparam logic [4:0] ST_WAIT_F   = 5'd12;
    localparam logic [4:0] ST_LATCH_F  = 5'd13;
    localparam logic [4:0] ST_WR_DEC   = 5'd14;
    localparam logic [4:0] ST_NEXT_K   = 5'd15;
    localparam logic [4:0] ST_DONE     = 5'd16;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    logic [4:0]        state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        f_q, f_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic              s_wren_raw;
    logic              dec_wren_raw;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    si_d    = 8'd0;
                    sj_d    = 8'd0;
                    f_d     = 8'd0;
                    k_d     = '0;
                    state_d = ST_INC_I;
                end
            end
            ST_INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = ST_RD_SI;
            end
            ST_RD_SI:    state_d = ST_WAIT_SI;
            ST_WAIT_SI:  state_d = ST_LATCH_SI;
            ST_LATCH_SI: begin
                si_d    = s_q;
                state_d = ST_CALC_J;
            end
            ST_CALC_J: begin
                j_d     = j_q + si_q;
                state_d = ST_RD_SJ;
            end
            ST_RD_SJ:    state_d = ST_WAIT_SJ;
            ST_WAIT_SJ:  state_d = ST_LATCH_SJ;
            ST_LATCH_SJ: begin
                sj_d    = s_q;
                state_d = ST_WR_I;
            end
            ST_WR_I:     state_d = ST_WR_J;
            ST_WR_J:     state_d = ST_RD_F;
            ST_RD_F:     state_d = ST_WAIT_F;
            ST_WAIT_F:   state_d = ST_LATCH_F;
            ST_LATCH_F: begin
                f_d     = s_q;
                state_d = ST_WR_DEC;
            end
            ST_WR_DEC:   state_d = ST_NEXT_K;
            ST_NEXT_K: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    state_d = ST_INC_I;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            f_q     <= 8'd0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            k_q     <= k_d;
        end
    end

    // The keystream address uses the pre-swap si/sj, which equal S[j]+S[i] after the swap.
    always_comb begin
        s_address    = 8'd0;
        s_data       = 8'd0;
        s_wren_raw   = 1'b0;
        dec_data     = 8'd0;
        dec_wren_raw = 1'b0;
        case (state_q)
            ST_RD_SI, ST_WAIT_SI, ST_LATCH_SI: s_address = i_q;
            ST_RD_SJ, ST_WAIT_SJ, ST_LATCH_SJ: s_address = j_q;
            ST_WR_I: begin
                s_address  = i_q;
                s_data     = sj_q;
                s_wren_raw = 1'b1;
            end
            ST_WR_J: begin
                s_address  = j_q;
                s_data     = si_q;
                s_wren_raw = 1'b1;
            end
            ST_RD_F, ST_WAIT_F, ST_LATCH_F:    s_address = si_q + sj_q;
            ST_WR_DEC: begin
                dec_data     = f_q ^ rom_q;
                dec_wren_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are masked by reset so an aborted run never commits a stray write.
    assign s_wren      = s_wren_raw & ~reset;
    assign dec_wren    = dec_wren_raw & ~reset;
    assign rom_address = k_q;
    assign dec_address = k_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Bench for rc4_prga_decryptor: S RAM, ROM and decrypted RAM models plus an RC4 reference scoreboard.
module tb_rc4_prga_decryptor;

    localparam int MSG_LEN = 32;
    localparam int MSG_AW  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        s_q;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] rom_address;
    logic [MSG_AW-1:0] dec_address;
    logic [7:0]        dec_data;
    logic              dec_wren;
    logic              busy;
    logic              done;

    logic [7:0]  s_mem   [256];
    logic [7:0]  model_s [256];
    logic [7:0]  rom_mem [MSG_LEN];
    logic [7:0]  dec_mem [MSG_LEN];
    logic [12:0] sb_q [$];
    logic [12:0] sb_e;

    int n_cmp = 0;
    int n_err = 0;
    int wren_cnt = 0;

    always #5 clk = ~clk;

    rc4_prga_decryptor #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .s_q         (s_q),
        .s_address   (s_address),
        .s_data      (s_data),
        .s_wren      (s_wren),
        .rom_q       (rom_q),
        .rom_address (rom_address),
        .dec_address (dec_address),
        .dec_data    (dec_data),
        .dec_wren    (dec_wren),
        .busy        (busy),
        .done        (done)
    );

    // Registered-read memories (one cycle read latency).
    always @(posedge clk) begin
        if (s_wren) s_mem[s_address] <= s_data;
        s_q   <= s_mem[s_address];
        rom_q <= rom_mem[rom_address];
        if (dec_wren) dec_mem[dec_address] <= dec_data;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dec_wren === 1'b1) begin
            wren_cnt++;
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_write", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check_val("dec_addr", int'(dec_address), int'(sb_e[12:8]));
                check_val("dec_data", int'(dec_data), int'(sb_e[7:0]));
            end
        end
    end

    task automatic load_identity();
        for (int n = 0; n < 256; n++) begin
            s_mem[n]   = 8'(n);
            model_s[n] = 8'(n);
        end
    endtask

    task automatic load_ksa();
        logic [7:0] key [3];
        logic [7:0] j;
        logic [7:0] t;
        key[0] = 8'h4B;
        key[1] = 8'h65;
        key[2] = 8'h79;
        j = 8'd0;
        for (int n = 0; n < 256; n++) model_s[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            j          = j + model_s[n] + key[n % 3];
            t          = model_s[n];
            model_s[n] = model_s[j];
            model_s[j] = t;
        end
        for (int n = 0; n < 256; n++) s_mem[n] = model_s[n];
    endtask

    task automatic load_rom_random();
        for (int n = 0; n < MSG_LEN; n++) rom_mem[n] = 8'($urandom_range(0, 255));
    endtask

    // Reference RC4 PRGA; expected writes queued when the stimulus is prepared.
    task automatic model_run();
        logic [7:0] i;
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] f;
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < MSG_LEN; k++) begin
            i          = i + 8'd1;
            j          = j + model_s[i];
            t          = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
            f          = model_s[8'(model_s[i] + model_s[j])];
            sb_q.push_back({5'(k), f ^ rom_mem[k]});
        end
    endtask

    task automatic run_msg(input int hold, input string tag);
        int cyc;
        int busy_lo;
        int s_diff;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold <= 1) start = 1'b0;
        wren_cnt = 0;
        check_val({tag, "_busy_at_start"}, int'(busy), 1);
        check_val({tag, "_done_drop"}, int'(done), 0);
        cyc     = 0;
        busy_lo = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == hold) start = 1'b0;
            if (done !== 1'b1 && busy !== 1'b1) busy_lo++;
        end
        check_val({tag, "_latency"}, cyc, 15 * MSG_LEN);
        check_val({tag, "_busy_low_cycles"}, busy_lo, 0);
        check_val({tag, "_busy_after_done"}, int'(busy), 0);
        check_val({tag, "_wren_count"}, wren_cnt, MSG_LEN);
        check_val({tag, "_sb_left"}, sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_done_hold"}, int'(done), 1);
        s_diff = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== model_s[n]) s_diff++;
        check_val({tag, "_s_final_diffs"}, s_diff, 0);
    endtask

    initial begin
        logic [7:0] ptxt [9];
        logic [7:0] ctxt [9];
        ptxt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        ctxt = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        reset = 1'b1;
        start = 1'b0;
        for (int n = 0; n < MSG_LEN; n++) dec_mem[n] = 8'h00;
        load_identity();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_s_wren", int'(s_wren), 0);
        check_val("rst_dec_wren", int'(dec_wren), 0);
        check_val("rst_s_address", int'(s_address), 0);
        check_val("rst_rom_address", int'(rom_address), 0);
        check_val("rst_dec_data", int'(dec_data), 0);
        @(negedge clk);
        reset = 1'b0;

        // Identity S, all-zero ciphertext: raw keystream.
        for (int n = 0; n < MSG_LEN; n++) rom_mem[n] = 8'h00;
        load_identity();
        model_run();
        run_msg(1, "ident");
        check_val("ident_dec0", int'(dec_mem[0]), 8'h02);
        check_val("ident_dec1", int'(dec_mem[1]), 8'h05);
        check_val("ident_dec2", int'(dec_mem[2]), 8'h07);

        // Identity S, rom[0]=FF, start held high well into the run.
        load_rom_random();
        rom_mem[0] = 8'hFF;
        load_identity();
        model_run();
        run_msg(200, "xor_hold");
        check_val("xor_dec0", int'(dec_mem[0]), 8'hFD);

        // Known-answer vector, restarted straight from DONE.
        load_rom_random();
        for (int n = 0; n < 9; n++) rom_mem[n] = ctxt[n];
        load_ksa();
        model_run();
        run_msg(1, "kat");
        for (int n = 0; n < 9; n++) check_val($sformatf("kat_dec%0d", n), int'(dec_mem[n]), int'(ptxt[n]));

        // Reset mid-run, start ignored while in reset, then a clean re-run.
        load_rom_random();
        load_identity();
        model_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_s_wren", int'(s_wren), 0);
        check_val("mid_rst_dec_wren", int'(dec_wren), 0);
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_done", int'(done), 0);
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("rst_start_ignored", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_after_rst", int'(busy), 0);
        load_rom_random();
        load_identity();
        model_run();
        run_msg(1, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
